// File: rtl/cnt_pkg.sv
// Shared constants for the modulo up/down counter: default widths and direction encoding.
package cnt_pkg;

  localparam int unsigned CNT_WIDTH_DEF   = 4;
  localparam int unsigned PRESC_WIDTH_DEF = 4;

  // Value of dir_i selecting the count direction
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/cnt_prescaler.sv
// Enable-gated prescaler: asserts tick once every div+1 enabled cycles.
// The phase counter holds while en is low and restarts from 0 on clr.
module cnt_prescaler
  import cnt_pkg::*;
#(
  parameter int unsigned PRESC_WIDTH = PRESC_WIDTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   en,
  input  logic                   clr,
  input  logic [PRESC_WIDTH-1:0] div,
  output logic                   tick
);

  localparam logic [PRESC_WIDTH-1:0] PrescOne = PRESC_WIDTH'(1);

  logic [PRESC_WIDTH-1:0] phase_q, phase_d;

  assign tick = en & (phase_q == div);

  // Next phase: wrap to 0 on tick, advance while enabled, hold otherwise
  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = phase_q + PrescOne;
    end
  end

  // Phase register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/cnt_mod_updown.sv
// Runtime-modulo up/down counter with prescaler, load, clear and wrap pulses.
// Range is 0..limit_i; ovf_o/udf_o pulse the cycle after an up/down wrap.
// Optional feature: define CNT_SAT_EN to add sat_i, which saturates instead of wrapping.
module cnt_mod_updown
  import cnt_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned PRESC_WIDTH = PRESC_WIDTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   cnt_en_i,
  input  logic                   cnt_clr_i,
  input  logic                   load_i,
  input  logic [CNT_WIDTH-1:0]   load_val_i,
  input  logic                   dir_i,
  input  logic [CNT_WIDTH-1:0]   limit_i,
  input  logic [PRESC_WIDTH-1:0] presc_i,
`ifdef CNT_SAT_EN
  input  logic                   sat_i,
`endif
  output logic [CNT_WIDTH-1:0]   cnt_o,
  output logic                   ovf_o,
  output logic                   udf_o,
  output logic                   tc_o
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 tick;
  logic                 sat;

`ifdef CNT_SAT_EN
  assign sat = sat_i;
`else
  assign sat = 1'b0;
`endif

  // Load also restarts the prescaler phase so the first step after it is a full period
  cnt_prescaler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_presc (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .en    (cnt_en_i),
    .clr   (cnt_clr_i | load_i),
    .div   (presc_i),
    .tick  (tick)
  );

  // Next count and wrap pulses: clear > load > step > hold
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    udf_d = 1'b0;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick) begin
      if (dir_i == DIR_UP) begin
        if (cnt_q >= limit_i) begin
          if (sat) begin
            cnt_d = limit_i;
          end else begin
            cnt_d = '0;
            ovf_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end else begin
        if (cnt_q == '0) begin
          if (!sat) begin
            cnt_d = limit_i;
            udf_d = 1'b1;
          end
        end else if (cnt_q > limit_i) begin
          // Out-of-range value (e.g. after a load) snaps back into range silently
          cnt_d = limit_i;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
    end
  end

  // Count and pulse registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
  assign tc_o  = (dir_i & (cnt_q == limit_i)) | (~dir_i & (cnt_q == '0));

endmodule

// File: doc/cnt_mod_updown.md
CNT_MOD_UPDOWN -- requirements
Module: cnt_mod_updown

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 4, counter width in bits (>=2).
REQ-002 SHALL have parameter PRESC_WIDTH, default 4, prescaler divide-value width in bits (>=1).
REQ-003 SHALL have port clk_i input 1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port rstn_i input 1: reset, synchronous, active-low.
REQ-005 SHALL have port cnt_en_i input 1: count enable, gates the prescaler.
REQ-006 SHALL have port cnt_clr_i input 1: synchronous clear of counter and prescaler.
REQ-007 SHALL have port load_i input 1: load load_val_i into counter.
REQ-008 SHALL have port load_val_i input CNT_WIDTH: load value.
REQ-009 SHALL have port dir_i input 1: 1 = count up, 0 = count down.
REQ-010 SHALL have port limit_i input CNT_WIDTH: runtime terminal value; count range 0..limit_i.
REQ-011 SHALL have port presc_i input PRESC_WIDTH: one count step every presc_i+1 enabled cycles.
REQ-012 SHALL have port cnt_o output CNT_WIDTH: registered count.
REQ-013 SHALL have port ovf_o output 1: registered one-cycle pulse on up-wrap limit_i->0.
REQ-014 SHALL have port udf_o output 1: registered one-cycle pulse on down-wrap 0->limit_i.
REQ-015 SHALL have port tc_o output 1: combinational; (dir_i & cnt_o==limit_i) | (~dir_i & cnt_o==0).

Function
REQ-016 SHALL apply per-edge priority: reset > cnt_clr_i > load_i > step > hold.
REQ-017 SHALL define tick = cnt_en_i & (prescaler count == presc_i); prescaler then returns to 0, else increments while cnt_en_i=1, holds while cnt_en_i=0.
REQ-018 SHALL with presc_i=0 step every enabled cycle (tick = cnt_en_i).
REQ-019 SHALL on up tick: cnt_o>=limit_i -> 0 with ovf_o=1 next cycle; else cnt_o+1.
REQ-020 SHALL on down tick: cnt_o==0 -> limit_i with udf_o=1; cnt_o>limit_i -> limit_i, no pulse; else cnt_o-1.
REQ-021 SHALL with limit_i=0 keep cnt_o=0 and pulse ovf_o (up) or udf_o (down) on every tick.
REQ-022 SHALL on load_i take load_val_i unchanged (even if >limit_i), clear the prescaler, no ovf/udf pulse.
REQ-023 SHALL on cnt_clr_i set cnt_o=0 and prescaler=0, no pulse; clr with load_i same cycle -> clr wins.
REQ-024 SHALL sample dir_i, limit_i, presc_i every cycle; changes take effect at next edge, no pipeline.
REQ-025 SHALL keep ovf_o/udf_o low in every cycle not directly following a wrap step.

Reset
REQ-026 SHALL on rstn_i=0 at a rising edge set cnt_o=0, ovf_o=0, udf_o=0, prescaler=0, regardless of other inputs.
REQ-027 SHALL resume counting from 0 with fresh prescaler phase on first edge after rstn_i returns high; reset mid-count discards state.

Configuration
REQ-028 SHALL with macro CNT_SAT_EN defined add input sat_i (1 bit): sat_i=1 holds cnt_o at limit_i (up) or 0 (down) instead of wrapping, with no ovf_o/udf_o pulse; sat_i=0 behaves as REQ-019..021.
REQ-029 SHALL without CNT_SAT_EN omit port sat_i and always wrap.

Structure
REQ-030 SHALL place default widths and a direction constant (DIR_UP=1, DIR_DOWN=0) in shared package cnt_pkg.
REQ-031 SHALL implement the prescaler as sub-module cnt_prescaler (inputs clk_i, rstn_i, en, clr, div; output tick).

Verification (CNT_WIDTH=4, PRESC_WIDTH=4)
REQ-032 SHALL check: reset, up, limit_i=9, presc_i=0, en=1 for 12 cycles -> cnt_o 1..9,0,1,2; ovf_o high exactly the cycle cnt_o becomes 0.
REQ-033 SHALL check: down, limit_i=5, start 0 -> cnt_o 5,4..0,5; udf_o pulses on each 0->5.
REQ-034 SHALL check: presc_i=2, up, en=1 -> cnt_o steps every 3rd cycle; en low 2 cycles mid-period stretches that period by 2.
REQ-035 SHALL check: load_i=1, load_val_i=12, limit_i=9, up -> cnt_o=12, next tick 0 + ovf_o; load_i with cnt_clr_i same cycle -> cnt_o=0.
REQ-036 SHALL check: rstn_i low one edge mid-count at cnt_o=7 -> cnt_o=0, outputs low that edge, count restarts 1,2.
REQ-037 SHALL check with CNT_SAT_EN: sat_i=1, up, limit_i=3 -> cnt_o 1,2,3,3,3, ovf_o never high.
